resp_misr_checker: RTL
======================

# resp_misr_checker

Sequential response compactor that sits directly downstream of the ISCAS-85 combinational benchmark (c880 class: 26 outputs). It accepts one response word per handshake and folds it into a 26-bit multiple-input signature register (MISR). After a programmed number of patterns it compares the signature with a golden value and flags pass/fail. The trojan-detection flow uses that flag to decide whether the circuit under test differs from the golden netlist.

## Interface
- `WIDTH`, 26: response and signature width; it matches the benchmark output bus.
- `POLY`, 26'h0000047: Galois feedback taps, x^26+x^6+x^2+x+1 (bits 6, 2, 1, 0).
- `SEED`, 26'h0000000: MISR value loaded on `start`.
- `N_PATTERNS`, 1024: responses compacted per run; legal range 1..2^16.
- `CNT_W`, $clog2(N_PATTERNS+1): width of the pattern counter.
- `clk` in, 1: single clock; all state changes on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: begin a run; sampled in IDLE and DONE only.
- `golden_sig` in, WIDTH: expected signature; sampled on the cycle the last response is accepted.
- `resp_valid` in, 1: a response word is present.
- `resp_data` in, WIDTH: response word (the benchmark `out` bus).
- `resp_ready` out, 1: block accepts a word this cycle.
- `busy` out, 1: state is RUN.
- `done` out, 1: state is DONE.
- `pass` out, 1: final signature equalled `golden_sig`; meaningful only while `done`=1.
- `signature` out, WIDTH: current MISR contents.
- `count` out, CNT_W: number of responses accepted in the current run.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `resp_ready`=0. On `start`=1: `signature`<=SEED, `count`<=0, `pass`<=0, go to RUN.
- RUN: `resp_ready`=1. A word is accepted when `resp_valid`&`resp_ready`.
- Per accepted word: `signature` <= ({sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0)) ^ `resp_data`, and `count`++.
- Last word (accepted while `count`==N_PATTERNS-1):
  - register the new signature;
  - `pass` <= (new signature == `golden_sig`);
  - go to DONE.
- No other state changes on the last word.
- When `resp_valid`=0 in RUN: hold all state. Stalls of any length are legal.
- `start` is ignored while in RUN; a run cannot be aborted except by reset.
- DONE: `resp_ready`=0. `signature`, `count` (=N_PATTERNS) and `pass` hold.
  - `start`=1 in DONE restarts exactly as from IDLE and goes to RUN.
  - Otherwise stay in DONE.
- `resp_data` is ignored whenever no handshake occurs.
- N_PATTERNS=1: the first accepted word also completes the run.
- Counter cannot overflow: CNT_W holds N_PATTERNS.

## Timing
- Reset: state=IDLE; `signature`=0, `count`=0, `pass`=0, `busy`=0, `done`=0, `resp_ready`=0.
  - Reset takes effect immediately and asynchronously, including mid-run.
  - After `rst_n` rises, the block waits in IDLE for `start`.
- `start` at edge k: `busy`=1 and `resp_ready`=1 from cycle k+1.
- Throughput: one word per cycle. A run with no stalls takes N_PATTERNS cycles in RUN.
- Last-word handshake at edge m: `done`=1, `busy`=0 and `pass` valid from cycle m+1 (1-cycle latency).
- All outputs are registered or decoded directly from state. No combinational path from `resp_valid` to `resp_ready`.

## Structure
- Package `misr_pkg` holds:
  - state enum `misr_state_t` (IDLE, RUN, DONE);
  - default POLY/SEED constants for the 26-bit benchmark width;
  - function `misr_next(sig, data, poly)`.
- Sub-module `misr_core`:
  - WIDTH/POLY/SEED register with `load` and `shift_en`;
  - used by the FSM wrapper `resp_misr_checker`.

## Test plan
- Basic compaction: N_PATTERNS=4, SEED=0; data 1,0,0,0 back-to-back.
  - Required: `signature` 1,2,4,8.
  - `done`=1 one cycle after the 4th word.
  - With `golden_sig`=26'h0000008: `pass`=1.
- Feedback wrap: SEED=26'h2000000, N=1, data 0 -> `signature`=26'h0000047.
  - With `golden_sig`=26'h0000046: `pass`=0.
- Stalls: N=4 with `resp_valid` toggled 1,0,0,1,1,0,1.
  - Required: same signature as the no-stall run; `count` increments only on handshakes.
- Reset mid-run: assert `rst_n`=0 after 2 of 4 words.
  - Required: outputs zero immediately.
  - A new `start` then yields a signature independent of the aborted words.
- Restart from DONE: `start` in DONE -> `signature`=SEED, `count`=0, `busy`=1 next cycle.
  - `start` pulsed during RUN has no effect.
- Golden-model check: 1024 random words applied to the c880 model versus a bit-flipped model.
  - Required: `pass`=1 on golden and `pass`=0 on the faulty model.

Source files
------------

// File: rtl/misr_pkg.sv
// misr_pkg: shared types, constants and next-state function
// for the 26-bit response MISR checker.
package misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } misr_state_t;

  localparam int MISR_W = 26;
  localparam logic [MISR_W-1:0] MISR_POLY = 26'h0000047;
  localparam logic [MISR_W-1:0] MISR_SEED = 26'h0000000;

  // Galois step: shift left, fold the MSB back through
  // the taps, then mix in the response word.
  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] data,
    input logic [MISR_W-1:0] poly
  );
    return {sig[MISR_W-2:0], 1'b0}
         ^ (sig[MISR_W-1] ? poly : '0)
         ^ data;
  endfunction

endpackage

// File: rtl/misr_core.sv
// misr_core: WIDTH-bit Galois MISR register.
// Ports: clk, rst_n, load (SEED), shift_en, data, sig, sig_next.
module misr_core
  import misr_pkg::*;
#(
  parameter int              WIDTH = MISR_W,
  parameter logic [WIDTH-1:0] POLY = MISR_POLY,
  parameter logic [WIDTH-1:0] SEED = MISR_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  if (WIDTH == MISR_W) begin : g_pkg
    assign sig_next = misr_next(sig, data, POLY);
  end else begin : g_gen
    assign sig_next = {sig[WIDTH-2:0], 1'b0}
                    ^ (sig[WIDTH-1] ? POLY : '0)
                    ^ data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (shift_en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/resp_misr_checker.sv
// resp_misr_checker: compacts N_PATTERNS responses into a MISR
// and compares the result with golden_sig (pass/done/busy/count).
module resp_misr_checker
  import misr_pkg::*;
#(
  parameter int               WIDTH      = MISR_W,
  parameter logic [WIDTH-1:0] POLY       = MISR_POLY,
  parameter logic [WIDTH-1:0] SEED       = MISR_SEED,
  parameter int               N_PATTERNS = 1024,
  parameter int               CNT_W      = $clog2(N_PATTERNS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] count
);

  misr_state_t      state;
  logic             accept;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] sig_next;

  // Ready is decoded from state only, never from resp_valid.
  assign resp_ready = (state == ST_RUN);
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

  assign accept = resp_ready && resp_valid;
  assign load   = start && (state != ST_RUN);
  assign last   = accept
               && (count == CNT_W'(N_PATTERNS - 1));

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (accept),
    .data     (resp_data),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            count <= '0;
            pass  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (last) begin
              pass  <= (sig_next == golden_sig);
              state <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
